// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and operand-delivery stage feeding alu1.
// Latches decoded operands/control from ID, resolves EX/MEM and MEM/WB
// forwarding for rs/rt, detects load-use hazards and inserts bubbles on
// stall or branch flush.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_*                       decoded instruction from ID
//   flush                      taken branch/jump, kills the ID instruction
//   exmem_*, memwb_*           forwarding sources
//   A_out, B_out               operands to alu1
//   aluop_out, shamt_out       alu1 opcode and shift amount
//   store_data_out             forwarded rt for stores
//   ex_*                       registered control/destination to EX/MEM
//   stall_out                  hold PC and IF/ID this cycle
//   stall_count                saturating count of stall cycles
module id_ex_operand_stage #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [31:0]            id_rs_val,
    input  logic [31:0]            id_rt_val,
    input  logic [31:0]            id_imm,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             id_rd,
    input  logic [4:0]             id_shamt,
    input  logic [5:0]             id_aluop,
    input  logic                   id_alusrc,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   id_memwrite,
    input  logic                   id_memtoreg,
    input  logic                   flush,
    input  logic                   exmem_regwrite,
    input  logic [4:0]             exmem_rd,
    input  logic [31:0]            exmem_result,
    input  logic                   memwb_regwrite,
    input  logic [4:0]             memwb_rd,
    input  logic [31:0]            memwb_result,
    output logic [31:0]            A_out,
    output logic [31:0]            B_out,
    output logic [5:0]             aluop_out,
    output logic [4:0]             shamt_out,
    output logic [31:0]            store_data_out,
    output logic                   ex_valid,
    output logic                   ex_regwrite,
    output logic                   ex_memread,
    output logic                   ex_memwrite,
    output logic                   ex_memtoreg,
    output logic [4:0]             ex_rd,
    output logic                   stall_out,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  aluop;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
    } ex_reg_t;

    ex_reg_t                ex_d, ex_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic                   hz;
    logic [31:0]            fwd_rs, fwd_rt;

    // Load-use hazard; rt is compared even for I-type, a deliberate
    // conservative extra stall.
    always_comb begin
        hz = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid &
             ((ex_q.rd == id_rs) | (ex_q.rd == id_rt));
        stall_out = hz & ~flush;
    end

    // Flush and stall both load an all-zero bubble, so flush winning over
    // stall needs no extra priority logic beyond masking stall_out.
    always_comb begin
        ex_d = '0;
        if (!flush && !stall_out && id_valid) begin
            ex_d.valid    = 1'b1;
            ex_d.rs_val   = id_rs_val;
            ex_d.rt_val   = id_rt_val;
            ex_d.imm      = id_imm;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.rd       = id_rd;
            ex_d.shamt    = id_shamt;
            ex_d.aluop    = id_aluop;
            ex_d.alusrc   = id_alusrc;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.memtoreg = id_memtoreg;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_out && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded.
    always_comb begin
        fwd_rs = ex_q.rs_val;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rs)) begin
            fwd_rs = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rs)) begin
            fwd_rs = memwb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_val;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rt)) begin
            fwd_rt = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rt)) begin
            fwd_rt = memwb_result;
        end
    end

    always_comb begin
        A_out          = fwd_rs;
        store_data_out = fwd_rt;
        B_out          = ex_q.alusrc ? ex_q.imm : fwd_rt;
        aluop_out      = ex_q.aluop;
        shamt_out      = ex_q.shamt;
        ex_valid       = ex_q.valid;
        ex_regwrite    = ex_q.regwrite;
        ex_memread     = ex_q.memread;
        ex_memwrite    = ex_q.memwrite;
        ex_memtoreg    = ex_q.memtoreg;
        ex_rd          = ex_q.rd;
        stall_count    = stall_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    localparam int unsigned CW   = 16;
    localparam int unsigned CW_S = 4;

    localparam int SEL_A   = 0;
    localparam int SEL_B   = 1;
    localparam int SEL_ALU = 2;
    localparam int SEL_SH  = 3;
    localparam int SEL_SD  = 4;
    localparam int SEL_V   = 5;
    localparam int SEL_RW  = 6;
    localparam int SEL_MR  = 7;
    localparam int SEL_RD  = 8;
    localparam int SEL_ST  = 9;
    localparam int SEL_CNT = 10;
    localparam int SEL_CNS = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_aluop;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;

    logic [31:0] a_out, b_out, sd_out;
    logic [5:0]  aluop_out;
    logic [4:0]  shamt_out, ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, stall_out;
    logic [CW-1:0] stall_count;

    logic [31:0] s_a_out, s_b_out, s_sd_out;
    logic [5:0]  s_aluop_out;
    logic [4:0]  s_shamt_out, s_ex_rd;
    logic        s_ex_valid, s_ex_regwrite, s_ex_memread, s_ex_memwrite, s_ex_memtoreg;
    logic        s_stall_out;
    logic [CW_S-1:0] s_stall_count;

    id_ex_operand_stage #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .flush(flush), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .A_out(a_out), .B_out(b_out), .aluop_out(aluop_out), .shamt_out(shamt_out),
        .store_data_out(sd_out), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_rd(ex_rd), .stall_out(stall_out), .stall_count(stall_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    id_ex_operand_stage #(.STALL_CNT_W(CW_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .flush(flush), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .A_out(s_a_out), .B_out(s_b_out), .aluop_out(s_aluop_out),
        .shamt_out(s_shamt_out), .store_data_out(s_sd_out), .ex_valid(s_ex_valid),
        .ex_regwrite(s_ex_regwrite), .ex_memread(s_ex_memread),
        .ex_memwrite(s_ex_memwrite), .ex_memtoreg(s_ex_memtoreg), .ex_rd(s_ex_rd),
        .stall_out(s_stall_out), .stall_count(s_stall_count)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_A:   return a_out;
            SEL_B:   return b_out;
            SEL_ALU: return {26'd0, aluop_out};
            SEL_SH:  return {27'd0, shamt_out};
            SEL_SD:  return sd_out;
            SEL_V:   return {31'd0, ex_valid};
            SEL_RW:  return {31'd0, ex_regwrite};
            SEL_MR:  return {31'd0, ex_memread};
            SEL_RD:  return {27'd0, ex_rd};
            SEL_ST:  return {31'd0, stall_out};
            SEL_CNT: return {16'd0, stall_count};
            SEL_CNS: return {28'd0, s_stall_count};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pops every expectation scheduled for the current cycle.
    exp_t        cur;
    logic [31:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            act = actual(cur.sel);
            total++;
            if (cur.cyc != cyc) begin
                bad++;
                $display("FAIL %s: missed its cycle %0d (now %0d)", cur.name, cur.cyc, cyc);
            end else if (act !== cur.val) begin
                bad++;
                $display("FAIL %s: got %h want %h (cycle %0d)", cur.name, act, cur.val, cyc);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_none();
        id_valid = 1'b0; id_rs_val = '0; id_rt_val = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0; id_aluop = '0;
        id_alusrc = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
        id_memwrite = 1'b0; id_memtoreg = 1'b0;
    endtask

    task automatic id_instr(input logic [31:0] rsv, input logic [31:0] rtv,
                            input logic [31:0] imm, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [4:0] sh, input logic [5:0] op,
                            input logic asrc, input logic rw, input logic mr,
                            input logic mw, input logic mtr);
        id_valid = 1'b1; id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh; id_aluop = op;
        id_alusrc = asrc; id_regwrite = rw; id_memread = mr;
        id_memwrite = mw; id_memtoreg = mtr;
    endtask

    task automatic fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                       input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        exmem_regwrite = erw; exmem_rd = erd; exmem_result = eres;
        memwb_regwrite = wrw; memwb_rd = wrd; memwb_result = wres;
    endtask

    // lw r8, 4(r1)
    task automatic id_lw8(input logic [4:0] base);
        id_instr(32'h100, 32'h0, 32'd4, base, 5'd8, 5'd8, 5'd0, 6'h20, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // add r9, r8, r2 (stale rs value 0, rt value 7)
    task automatic id_dep_add();
        id_instr(32'h0, 32'h7, 32'h0, 5'd8, 5'd2, 5'd9, 5'd0, 6'h20, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (1000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        id_instr(32'h16, 32'h0F, 32'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset holds everything at zero even with a live ID instruction.
        step();
        expect_val(SEL_A, 32'h0, "rst_a");
        expect_val(SEL_B, 32'h0, "rst_b");
        expect_val(SEL_SD, 32'h0, "rst_sd");
        expect_val(SEL_ALU, 32'h0, "rst_aluop");
        expect_val(SEL_V, 32'h0, "rst_valid");
        expect_val(SEL_RW, 32'h0, "rst_regwrite");
        expect_val(SEL_RD, 32'h0, "rst_rd");
        expect_val(SEL_ST, 32'h0, "rst_stall");
        expect_val(SEL_CNT, 32'h0, "rst_count");
        rst_n = 1'b1;

        step();
        expect_val(SEL_A, 32'h16, "cap_a");
        expect_val(SEL_B, 32'h0F, "cap_b");
        expect_val(SEL_ALU, 32'h20, "cap_aluop");
        expect_val(SEL_RD, 32'd3, "cap_rd");
        expect_val(SEL_RW, 32'd1, "cap_regwrite");
        expect_val(SEL_V, 32'd1, "cap_valid");
        id_instr(32'h1111, 32'h2222, 32'h0, 5'd5, 5'd6, 5'd7, 5'd4, 6'h21, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0);

        // Forwarding priority on rs.
        step();
        fwd(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
        expect_val(SEL_A, 32'hAAAA, "fwd_exmem_prio");
        expect_val(SEL_B, 32'h2222, "fwd_b_latched");
        expect_val(SEL_SH, 32'd4, "shamt");
        expect_val(SEL_ALU, 32'h21, "aluop2");
        step();
        fwd(1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
        expect_val(SEL_A, 32'hBBBB, "fwd_memwb");
        step();
        fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
        expect_val(SEL_A, 32'h1111, "fwd_r0_blocked");
        step();
        fwd(1'b1, 5'd6, 32'hCCCC, 1'b1, 5'd6, 32'hDDDD);
        expect_val(SEL_B, 32'hCCCC, "fwd_rt_exmem_b");
        expect_val(SEL_SD, 32'hCCCC, "fwd_rt_exmem_sd");
        expect_val(SEL_A, 32'h1111, "fwd_rs_nomatch");
        id_instr(32'h1, 32'h9999, 32'hFFFF_FFF0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h08, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b0);

        // Immediate select; store data still carries forwarded rt.
        step();
        fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h1234);
        expect_val(SEL_B, 32'hFFFF_FFF0, "imm_b");
        expect_val(SEL_SD, 32'h1234, "imm_sd");
        expect_val(SEL_A, 32'h1, "imm_a");
        id_lw8(5'd1);

        // Load-use: one stall, bubble, then MEM/WB forwarding.
        step();
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        id_dep_add();
        expect_val(SEL_ST, 32'd1, "lu_stall");
        expect_val(SEL_MR, 32'd1, "lu_memread");
        expect_val(SEL_RD, 32'd8, "lu_rd");
        expect_val(SEL_CNT, 32'd0, "lu_count0");
        step();
        expect_val(SEL_V, 32'd0, "lu_bubble_valid");
        expect_val(SEL_RW, 32'd0, "lu_bubble_rw");
        expect_val(SEL_ST, 32'd0, "lu_no_restall");
        expect_val(SEL_CNT, 32'd1, "lu_count1");
        step();
        fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h55);
        expect_val(SEL_A, 32'h55, "lu_fwd_a");
        expect_val(SEL_B, 32'h7, "lu_b");
        expect_val(SEL_V, 32'd1, "lu_dep_valid");
        expect_val(SEL_ST, 32'd0, "lu_dep_nostall");
        id_lw8(5'd1);

        // Flush wins over stall.
        step();
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        id_dep_add();
        flush = 1'b1;
        expect_val(SEL_ST, 32'd0, "flush_stall_masked");
        expect_val(SEL_CNT, 32'd1, "flush_count");
        step();
        flush = 1'b0;
        id_none();
        expect_val(SEL_V, 32'd0, "flush_bubble_valid");
        expect_val(SEL_MR, 32'd0, "flush_bubble_mr");
        expect_val(SEL_CNT, 32'd1, "flush_count2");
        id_instr(32'h100, 32'h0, 32'd4, 5'd1, 5'd0, 5'd0, 5'd0, 6'h20, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b1);

        // Load to r0 never stalls.
        step();
        id_lw8(5'd0);
        expect_val(SEL_MR, 32'd1, "r0_load_mr");
        expect_val(SEL_ST, 32'd0, "r0_no_stall");

        // Invalid ID instruction never stalls.
        step();
        id_dep_add();
        id_valid = 1'b0;
        expect_val(SEL_ST, 32'd0, "idinvalid_no_stall");
        step();
        expect_val(SEL_V, 32'd0, "idinvalid_bubble");
        id_lw8(5'd1);

        // Hazard through rt.
        step();
        id_instr(32'h3, 32'h0, 32'h0, 5'd3, 5'd8, 5'd12, 5'd0, 6'h20, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0);
        expect_val(SEL_ST, 32'd1, "rt_stall");
        expect_val(SEL_CNT, 32'd1, "rt_count_before");
        step();
        id_none();
        expect_val(SEL_ST, 32'd0, "rt_stall_drop");
        expect_val(SEL_CNT, 32'd2, "rt_count_after");

        // Alternating capture/stall: 19 stalls, narrow counter saturates at 15.
        step();
        id_instr(32'h100, 32'h0, 32'd4, 5'd8, 5'd8, 5'd8, 5'd0, 6'h20, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 38; i++) begin
            step();
        end
        expect_val(SEL_CNT, 32'd21, "sat_wide_count");
        expect_val(SEL_CNS, 32'hF, "sat_narrow_count");
        expect_val(SEL_ST, 32'd0, "sat_end_nostall");
        id_none();

        // Reset asserted mid-stall.
        step();
        id_lw8(5'd1);
        step();
        id_dep_add();
        #1 rst_n = 1'b0;
        expect_val(SEL_ST, 32'd0, "midrst_stall");
        expect_val(SEL_V, 32'd0, "midrst_valid");
        expect_val(SEL_MR, 32'd0, "midrst_mr");
        expect_val(SEL_CNT, 32'd0, "midrst_count");
        expect_val(SEL_CNS, 32'd0, "midrst_count_s");
        step();
        rst_n = 1'b1;
        expect_val(SEL_V, 32'd0, "midrst_held");
        step();
        expect_val(SEL_V, 32'd1, "postrst_valid");
        expect_val(SEL_B, 32'h7, "postrst_b");
        expect_val(SEL_RD, 32'd9, "postrst_rd");
        expect_val(SEL_ST, 32'd0, "postrst_nostall");
        id_none();

        step();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-delivery stage that sits directly upstream of alu1 in the pipelined MIPS32 core. It latches decoded operands and control from ID and resolves EX/MEM and MEM/WB forwarding. It drives alu1's A_in, B_in, aluop and shamt. It also detects load-use hazards, requests an IF/ID hold, and inserts bubbles on stall or branch flush.

Parameters:
STALL_CNT_W, 16, width of the saturating load-use stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_val  in  32  register-file read of rs
id_rt_val  in  32  register-file read of rt
id_imm  in  32  immediate, already sign/zero-extended by ID
id_rs, id_rt, id_rd  in  5 each  source and destination register numbers (id_rd already muxed rt/rd/31)
id_shamt  in  5  shift amount field
id_aluop  in  6  alu1 opcode
id_alusrc  in  1  1: B operand = immediate
id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  downstream control
flush  in  1  taken branch/jump; kill ID instruction
exmem_regwrite  in  1  EX/MEM writes a register
exmem_rd  in  5  EX/MEM destination
exmem_result  in  32  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB writes a register
memwb_rd  in  5  MEM/WB destination
memwb_result  in  32  MEM/WB writeback value
A_out  out  32  to alu1 A_in
B_out  out  32  to alu1 B_in
aluop_out  out  6  to alu1 aluop
shamt_out  out  5  to alu1 shamt
store_data_out  out  32  forwarded rt for stores
ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control to EX/MEM
ex_rd  out  5  registered destination
stall_out  out  1  hold PC and IF/ID this cycle
stall_count  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- EX register holds valid, rs_val, rt_val, imm, rs, rt, rd, shamt, aluop, alusrc and the four control bits. It loads every cycle; there is no enable.
- Reset (rst_n low, asynchronous): all EX register fields and stall_count clear to 0. This gives A_out = B_out = store_data_out = 0, aluop_out = 0, shamt_out = 0, all control outputs 0, and stall_out = 0.
- Bubble: all EX register fields are loaded with 0. A bubble carries regwrite = memread = memwrite = 0, so it has no architectural effect.
- Hazard (combinational): hz = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (ex_rd == id_rt)).
  - rt is compared even for I-type instructions. This conservative extra stall is intended.
- stall_out = hz & ~flush.
- Next EX register load, in priority order:
  - flush = 1: bubble (wins over stall).
  - else stall_out = 1: bubble. The upstream stage re-presents the same ID instruction next cycle.
  - else id_valid = 0: bubble.
  - else: capture all id_* inputs.
- Forwarding (combinational from EX register and forwarding inputs) for source X in {rs, rt}:
  - if exmem_regwrite & exmem_rd != 0 & exmem_rd == ex_X: use exmem_result;
  - else if memwb_regwrite & memwb_rd != 0 & memwb_rd == ex_X: use memwb_result;
  - else use the latched ex_X_val.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Output assignments:
  - A_out = forwarded rs.
  - store_data_out = forwarded rt.
  - B_out = ex_alusrc ? ex_imm : forwarded rt.
  - aluop_out, shamt_out and ex_* are direct register outputs.
- Latency: an ID instruction appears at the alu1 inputs one cycle after capture. A load followed by a dependent instruction costs exactly one stall cycle; the dependent instruction then receives the value via MEM/WB forwarding.
- Consecutive hazards: each hazard cycle inserts one bubble. After a bubble, ex_memread = 0, so the same pair cannot stall twice.
- stall_count increments by 1 on every rising edge where stall_out = 1 and saturates at all-ones (no wrap).
- Reset asserted mid-stall: the stall drops immediately and the EX register clears. The first instruction after reset is captured normally.

Test Plan:
- Reset/capture:
  - rst_n = 0: all outputs 0.
  - Release, then present id_rs_val = 0x16, id_rt_val = 0x0F, aluop = 100000, alusrc = 0, rs = 1, rt = 2, rd = 3.
  - Next cycle: A_out = 0x16, B_out = 0x0F, aluop_out = 100000, ex_rd = 3, ex_regwrite = 1.
- Forwarding priority:
  - EX holds rs = 5; set exmem_regwrite = 1, exmem_rd = 5, exmem_result = 0xAAAA, and memwb_rd = 5, memwb_result = 0xBBBB → A_out = 0xAAAA.
  - Drop exmem_regwrite → A_out = 0xBBBB.
  - Set rd = 0 on both paths → A_out = latched value.
- Immediate select: alusrc = 1, imm = 0xFFFFFFF0, rt forwarded = 0x1234 → B_out = 0xFFFFFFF0 and store_data_out = 0x1234.
- Load-use:
  - lw to r8, then ID presents rs = 8 → stall_out = 1 for one cycle; EX gets a bubble (ex_valid = 0); stall_count = 1.
  - Next cycle (memwb_rd = 8, memwb_result = 0x55): A_out = 0x55 and stall_out = 0.
- Flush over stall: the load-use condition and flush = 1 occur in the same cycle → stall_out = 0, EX gets a bubble, stall_count unchanged.
- Saturation: force 2^STALL_CNT_W + 3 stall cycles → stall_count = 0xFFFF at STALL_CNT_W = 16.
